// File: rtl/ysyx_22040759_gpr_wb.sv
// GPR write-back arbiter (LSU over EXU, one registered write per cycle) and
// pending-register scoreboard. Define YSYX_22040759_WB_PERF_EN to add the stall_cnt/wb_cnt counters.
module ysyx_22040759_gpr_wb #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic            iss_wen,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [4:0]      exu_rd,
  input  logic [XLEN-1:0] exu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            gpr_wen,
  output logic [4:0]      gpr_waddr,
  output logic [XLEN-1:0] gpr_wdata,
  output logic            wb_err
`ifdef YSYX_22040759_WB_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     wb_cnt
`endif
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;
  logic            w_acc;
  logic [4:0]      w_acc_rd;
  logic [XLEN-1:0] w_acc_data;
  logic            w_wr;
  logic            w_hazard;
  logic            w_iss_set;

  assign lsu_ready  = 1'b1;
  assign exu_ready  = !lsu_valid;
  assign w_acc      = lsu_valid || exu_valid;
  assign w_acc_rd   = lsu_valid ? lsu_rd   : exu_rd;
  assign w_acc_data = lsu_valid ? lsu_data : exu_data;
  assign w_wr       = w_acc && (w_acc_rd != 5'd0);

  assign w_hazard = ((iss_rs1 != 5'd0) && r_pending[iss_rs1]) ||
                    ((iss_rs2 != 5'd0) && r_pending[iss_rs2]) ||
                    (iss_wen && (iss_rd != 5'd0) && r_pending[iss_rd]);
  assign iss_ready = !w_hazard;
  assign w_iss_set = iss_valid && iss_ready && iss_wen && (iss_rd != 5'd0);

  // Clear applied before set so a same-register collision leaves the bit pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (gpr_wen) w_pending_nxt[gpr_waddr] = 1'b0;
    if (w_iss_set) w_pending_nxt[iss_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
      wb_err    <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      gpr_wen   <= w_wr;
      if (w_wr) begin
        gpr_waddr <= w_acc_rd;
        gpr_wdata <= w_acc_data;
      end
      if (w_wr && !r_pending[w_acc_rd]) wb_err <= 1'b1;
    end
  end

`ifdef YSYX_22040759_WB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      wb_cnt    <= '0;
    end else begin
      if (iss_valid && !iss_ready) stall_cnt <= stall_cnt + 32'd1;
      if (gpr_wen) wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040759_gpr_wb.sv
// Bench for ysyx_22040759_gpr_wb: directed scenarios, then randomized traffic
// checked against a pending-set reference model.
module tb_ysyx_22040759_gpr_wb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, iss_wen;
  logic        iss_ready;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        exu_valid, exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        wb_err;
`ifdef YSYX_22040759_WB_PERF_EN
  logic [31:0] stall_cnt, wb_cnt;
  int unsigned m_stall, m_wb;
`endif

  ysyx_22040759_gpr_wb #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_wen(iss_wen),
    .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .wb_err(wb_err)
`ifdef YSYX_22040759_WB_PERF_EN
    , .stall_cnt(stall_cnt), .wb_cnt(wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: set of registers awaiting a result, and the expected write port.
  bit          mp[32];
  bit          m_wen, m_err;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          last_acc_lsu, last_acc_exu, last_fire;
  bit          outst[32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 0; iss_wen = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    exu_valid = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  task automatic model_reset();
    foreach (mp[i]) begin mp[i] = 0; outst[i] = 0; end
    m_wen = 0; m_err = 0; m_waddr = 0; m_wdata = 0;
`ifdef YSYX_22040759_WB_PERF_EN
    m_stall = 0; m_wb = 0;
`endif
  endtask

  function automatic bit exp_ready();
    bit blocked;
    blocked = (iss_rs1 != 0 && mp[iss_rs1]) || (iss_rs2 != 0 && mp[iss_rs2]) ||
              (iss_wen && iss_rd != 0 && mp[iss_rd]);
    return !blocked;
  endfunction

  // Called at posedge+1 after inputs are driven; returns at the next posedge+1.
  task automatic tick();
    bit er, acc, nerr;
    logic [4:0]  ard;
    logic [31:0] ad;
    #2;
    er = exp_ready();
    chk("iss_ready", iss_ready, er);
    chk("exu_ready", exu_ready, !lsu_valid);
    chk("lsu_ready", lsu_ready, 1);
    acc = lsu_valid || exu_valid;
    ard = lsu_valid ? lsu_rd : exu_rd;
    ad  = lsu_valid ? lsu_data : exu_data;
    last_fire    = iss_valid && er && iss_wen && iss_rd != 0;
    last_acc_lsu = lsu_valid;
    last_acc_exu = exu_valid && !lsu_valid;
`ifdef YSYX_22040759_WB_PERF_EN
    if (iss_valid && !er) m_stall++;
    if (m_wen) m_wb++;
`endif
    nerr = m_err || (acc && ard != 0 && !mp[ard]);
    if (m_wen) mp[m_waddr] = 0;
    if (last_fire) mp[iss_rd] = 1;
    m_err = nerr;
    m_wen = acc && ard != 0;
    if (m_wen) begin m_waddr = ard; m_wdata = ad; end
    @(posedge clk); #1;
    chk("gpr_wen", gpr_wen, m_wen);
    chk("wb_err", wb_err, m_err);
    if (m_wen) begin
      chk("gpr_waddr", gpr_waddr, m_waddr);
      chk("gpr_wdata", gpr_wdata, m_wdata);
    end
`ifdef YSYX_22040759_WB_PERF_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("wb_cnt", wb_cnt, m_wb);
`endif
  endtask

  // Asynchronous reset pulse taken between edges; outputs must drop immediately.
  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_wen", gpr_wen, 0);
    chk("rst_waddr", gpr_waddr, 0);
    chk("rst_wdata", gpr_wdata, 0);
    chk("rst_err", wb_err, 0);
    model_reset();
    idle();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic issue(input bit wen, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    iss_valid = 1; iss_wen = wen; iss_rd = rd; iss_rs1 = rs1; iss_rs2 = rs2;
  endtask

  function automatic logic [4:0] pick_rd();
    logic [4:0] r;
    for (int k = 0; k < 8; k++) begin
      r = 5'($urandom_range(1, 7));
      if (outst[r] && !(exu_valid && exu_rd == r)) return r;
    end
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    model_reset();
    idle();
    rst_n = 0;
    #12;
    chk("init_wen", gpr_wen, 0);
    chk("init_err", wb_err, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Issue rd=5, then a reader of x5 stalls.
    issue(1, 5, 0, 0);
    #2 chk("t1_ready", iss_ready, 1);
    tick();
    issue(0, 0, 5, 0);
    #2 chk("t1_raw_stall", iss_ready, 0);
    tick();

    // EXU writes x5; x5 stays pending during the write cycle.
    exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF;
    tick();
    idle(); issue(0, 0, 5, 0);
    chk("t2_wen", gpr_wen, 1);
    chk("t2_waddr", gpr_waddr, 5);
    chk("t2_wdata", gpr_wdata, 32'hDEADBEEF);
    #2 chk("t2_still_pending", iss_ready, 0);
    tick();
    #2 chk("t2_visible", iss_ready, 1);
    tick();

    // Simultaneous results: LSU first, EXU held.
    idle(); issue(1, 3, 0, 0); tick();
    issue(1, 4, 0, 0); tick();
    idle();
    exu_valid = 1; exu_rd = 3; exu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h22;
    #2 chk("t3_exu_blocked", exu_ready, 0);
    tick();
    lsu_valid = 0;
    chk("t3_w1_addr", gpr_waddr, 4);
    chk("t3_w1_data", gpr_wdata, 32'h22);
    tick();
    exu_valid = 0;
    chk("t3_w2_addr", gpr_waddr, 3);
    chk("t3_w2_data", gpr_wdata, 32'h11);
    tick();

    // Unexpected result for x9 sets the sticky error; rd=0 writes nothing.
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    tick();
    lsu_rd = 0; lsu_data = 32'h55;
    chk("t5_w9", gpr_waddr, 9);
    chk("t5_err", wb_err, 1);
    tick();
    lsu_valid = 0;
    chk("t5_rd0_nowen", gpr_wen, 0);
    chk("t5_err_sticky", wb_err, 1);
    tick();

    // x7 written (unpending) in the same cycle it is issued: set wins.
    exu_valid = 1; exu_rd = 7; exu_data = 32'h77;
    tick();
    idle(); issue(1, 7, 0, 0);
    #2 chk("t4_issue_ok", iss_ready, 1);
    tick();
    issue(1, 7, 0, 0);
    #2 chk("t4_waw_stall", iss_ready, 0);
    tick();

    // Reset while x5 pending and a write in flight; then three stall cycles.
    idle(); issue(1, 5, 0, 0); tick();
    idle(); lsu_valid = 1; lsu_rd = 5; lsu_data = 32'h5A5A;
    tick();
    chk("t6_wen_before", gpr_wen, 1);
    do_reset();
    issue(0, 0, 5, 0);
    #2 chk("t6_after_reset", iss_ready, 1);
    tick();
    issue(1, 6, 0, 0); tick();
    issue(0, 0, 6, 0); tick(); tick(); tick();
    idle();
`ifdef YSYX_22040759_WB_PERF_EN
    chk("t6_stall3", stall_cnt, 3);
`endif
    exu_valid = 1; exu_rd = 6; exu_data = 32'h66; tick();
    idle(); tick();

    // Randomized traffic over x0..x7 for dense hazards.
    for (int c = 0; c < 3000; c++) begin
      if (c % 600 == 599) do_reset();
      iss_valid = 1'($urandom_range(0, 1));
      iss_wen   = ($urandom_range(0, 3) != 0);
      iss_rd    = 5'($urandom_range(0, 7));
      iss_rs1   = 5'($urandom_range(0, 7));
      iss_rs2   = 5'($urandom_range(0, 7));
      if (!(exu_valid && !last_acc_exu)) begin
        exu_valid = ($urandom_range(0, 2) == 0);
        exu_rd    = pick_rd();
        exu_data  = $urandom;
      end
      lsu_valid = ($urandom_range(0, 3) == 0);
      lsu_rd    = pick_rd();
      lsu_data  = $urandom;
      tick();
      if (last_fire) outst[iss_rd] = 1;
      if (last_acc_lsu) outst[lsu_rd] = 0;
      if (last_acc_exu) outst[exu_rd] = 0;
      if (last_acc_exu) exu_valid = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/ysyx_22040759_gpr_wb.md
Name: ysyx_22040759_gpr_wb

Overview:
Write-back and scoreboard unit that drives the single GPR write port (wen/waddr/wdata) and gates instruction issue on register hazards. It merges results from the EXU and the LSU through a fixed-priority arbiter into one registered write per cycle. It also keeps a per-register pending bit that stalls issue on RAW and WAW hazards. It sits between the issue stage, the execution units and the GPR file.

Parameters:
XLEN, 32, data width of results and of the GPR write port
NREG, 32, number of architectural registers; register addresses are 5 bits; x0 is hard-wired zero

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
iss_valid  in  1  issue stage presents an instruction
iss_ready  out  1  instruction may issue this cycle (no hazard)
iss_wen  in  1  instruction writes a destination register
iss_rd  in  5  destination register
iss_rs1  in  5  source register 1
iss_rs2  in  5  source register 2
exu_valid  in  1  EXU result valid
exu_ready  out  1  EXU result accepted
exu_rd  in  5  EXU destination register
exu_data  in  XLEN  EXU result
lsu_valid  in  1  LSU load result valid
lsu_ready  out  1  LSU result accepted
lsu_rd  in  5  LSU destination register
lsu_data  in  XLEN  LSU result
gpr_wen  out  1  GPR write enable (registered)
gpr_waddr  out  5  GPR write address (registered)
gpr_wdata  out  XLEN  GPR write data (registered)
wb_err  out  1  sticky flag: a result arrived for a register that was not pending

Behaviour:
- Reset (rst_n=0, asynchronous): pending[31:1]=0, gpr_wen=0, gpr_waddr=0, gpr_wdata=0, wb_err=0. Reset asserted mid-operation discards any in-flight write.
- Arbitration:
  - lsu_ready=1 always.
  - exu_ready=!lsu_valid. LSU has priority.
  - At most one result is accepted per cycle.
- Write port latency:
  - A result accepted at edge N drives gpr_wen=1 with its rd and data for cycle N+1.
  - The GPR captures the write at edge N+1.
  - If no result is accepted at edge N, gpr_wen=0 in cycle N+1.
- rd=0 result: accepted, gpr_wen stays 0, no pending change, no error.
- Scoreboard:
  - pending[rd] is set at the edge where iss_valid && iss_ready && iss_wen && rd!=0.
  - pending[gpr_waddr] is cleared at the edge where gpr_wen=1.
  - If set and clear hit the same register at the same edge, set wins (pending stays 1).
- Hazard (combinational):
  - iss_ready=0 if (rs1!=0 && pending[rs1]) or (rs2!=0 && pending[rs2]) or (iss_wen && rd!=0 && pending[rd]).
  - Otherwise iss_ready=1.
  - iss_ready does not depend on iss_valid.
- Visibility: a register written in cycle N+1 stays pending during N+1, so a consumer issues no earlier than N+2. No forwarding.
- Error:
  - wb_err is set when a result is accepted with rd!=0 and pending[rd]=0.
  - The write still proceeds.
  - wb_err is cleared only by reset.
- Both valid together: the LSU result is written; the EXU holds exu_valid, exu_rd and exu_data stable until exu_ready=1.

Optional Feature:
YSYX_22040759_WB_PERF_EN:
- Defined: adds outputs stall_cnt (32) and wb_cnt (32), both reset to 0.
  - stall_cnt increments each cycle with iss_valid && !iss_ready.
  - wb_cnt increments each cycle with gpr_wen=1.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Reset, then issue rd=5 (rs1=rs2=0) -> iss_ready=1, pending[5]=1; the next issue with rs1=5 sees iss_ready=0.
2. EXU result rd=5 data=0xDEADBEEF accepted at edge N -> gpr_wen=1, waddr=5, wdata=0xDEADBEEF in cycle N+1; pending[5] cleared at N+1; rs1=5 issue has iss_ready=1 in cycle N+2.
3. exu_valid and lsu_valid together (rd=3/0x11, rd=4/0x22, both pending) -> cycle 1 writes x4=0x22 with exu_ready=0; cycle 2 writes x3=0x11.
4. Issue rd=7 in the same cycle that gpr_wen writes x7 -> pending[7]=1 afterwards; a WAW issue to rd=7 stalls.
5. Result rd=9 with pending[9]=0 -> x9 still written, wb_err=1 and stays set; result rd=0 -> no gpr_wen, wb_err unchanged.
6. Reset pulse while pending[5]=1 and gpr_wen=1 -> all outputs 0 immediately; after release, rs1=5 issue has iss_ready=1. With PERF_EN, 3 stall cycles give stall_cnt=3.
